baud_gen_mc: RTL and testbench
==============================

BAUD_GEN_MC -- requirements
Module: baud_gen_mc

Interface
REQ-001 Parameter CNT_W, 16, accumulator and config field width (4..32).
REQ-002 Parameter OSR, 16, oversample ticks per bit (power of two, 4..64).
REQ-003 Parameter DEF_FREQ, 16'd1152, active freq after reset.
REQ-004 Parameter DEF_LIMIT, 16'd30098, active limit after reset.
REQ-005 clock  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  run; low holds generator idle.
REQ-008 cfg_valid  in  1  new config offered.
REQ-009 cfg_ready  out  1  config slot free; transfer when cfg_valid&&cfg_ready.
REQ-010 cfg_freq  in  CNT_W  increment per cycle.
REQ-011 cfg_limit  in  CNT_W  wrap threshold.
REQ-012 sync  in  1  restart bit phase (RX start-edge alignment).
REQ-013 ce_os  out  1  oversample tick, one-cycle pulse.
REQ-014 ce_mid  out  1  mid-bit tick, one-cycle pulse.
REQ-015 ce_bit  out  1  end-of-bit tick, one-cycle pulse.
REQ-016 cfg_err  out  1  one-cycle pulse: rejected config.

Function
REQ-017 Accumulator acc (CNT_W) SHALL: if acc>=limit, acc<=acc-limit; else acc<=acc+freq; sum computed CNT_W+1 wide, truncated to CNT_W.
REQ-018 ce_os SHALL be registered, asserted the cycle after acc>=limit is evaluated true, giving freq ticks per (freq+limit) cycles.
REQ-019 Phase counter ph (log2(OSR) bits) SHALL increment on each ce_os event, wrapping OSR-1 -> 0.
REQ-020 ce_mid SHALL assert coincident with the ce_os whose event moves ph from OSR/2-1 to OSR/2; ce_bit with the ce_os wrapping ph from OSR-1 to 0.
REQ-021 sync high SHALL clear acc and ph next cycle and suppress all ticks that cycle; sync wins over a simultaneous tick.
REQ-022 Config handshake: accepted fields go into a pending register; cfg_ready SHALL drop the cycle after acceptance and rise the cycle after the pending config is applied.
REQ-023 Pending config SHALL be applied on the first cycle with enable low, or with acc>=limit (tick cycle); on apply, acc<=0, ph unchanged, that tick still issued.
REQ-024 Config with cfg_freq==0, cfg_limit==0, or cfg_freq+cfg_limit>=2^CNT_W SHALL be accepted (cfg_ready handshake completes) but discarded, with cfg_err pulsed one cycle later; active config unchanged, cfg_ready stays high.
REQ-025 enable low SHALL hold acc=0, ph=0, all ce_* low; on enable rise, counting restarts from acc=0.
REQ-026 sync and cfg apply in same cycle: both take effect (acc=0, ph=0, new config active).

Reset
REQ-027 reset SHALL set acc=0, ph=0, ce_os=ce_mid=ce_bit=cfg_err=0, cfg_ready=1, pending empty, active config = DEF_FREQ/DEF_LIMIT.
REQ-028 reset mid-operation SHALL discard any pending config; no tick emitted until reset deasserts and enable high.

Structure
REQ-029 Package baud_pkg SHALL hold DEF_FREQ/DEF_LIMIT defaults, OSR_W = log2(OSR) constant function, and the config struct (freq, limit).
REQ-030 One sub-module baud_acc (accumulator + ce_os) SHALL be instantiated; phase, handshake and error logic live in baud_gen_mc.

Verification
REQ-031 freq=1, limit=3, OSR=16, enable=1 -> ce_os every 4 cycles, ce_mid at 32 cycles, ce_bit every 64 cycles.
REQ-032 Defaults (1152/30098) over 31250 cycles -> exactly 1152 ce_os, 72 ce_bit, max ce_os gap 28 cycles.
REQ-033 sync pulse at ph=9 -> no tick that cycle, next ce_mid exactly 8 ce_os ticks later.
REQ-034 cfg 1/1 sent while running 1/3 -> cfg_ready low until next tick cycle, then ce_os every 2 cycles.
REQ-035 cfg_freq=0 -> handshake completes, cfg_err one pulse, tick rate unchanged.
REQ-036 reset asserted with config pending -> outputs 0 immediately, cfg_ready=1, rate returns to defaults.

Source files
------------

// File: rtl/baud_pkg.sv
// Baud generator shared definitions: reset defaults, phase-width helper and
// the runtime configuration record (increment and wrap threshold).
package baud_pkg;

  // Widest accumulator the generator supports; config records are carried at
  // this width and narrowed to the instance width where they are used.
  localparam int CFG_W_MAX = 32;

  // Reset-time rate: 1152 ticks per 31250 cycles.
  localparam logic [15:0] BAUD_DEF_FREQ  = 16'd1152;
  localparam logic [15:0] BAUD_DEF_LIMIT = 16'd30098;

  typedef struct packed {
    logic [CFG_W_MAX-1:0] freq;
    logic [CFG_W_MAX-1:0] limit;
  } baud_cfg_t;

  // Number of bits needed to count 0..osr-1 (osr is a power of two).
  function automatic int osr_w(input int osr);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < osr) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/baud_acc.sv
// Fractional rate accumulator: adds freq each cycle, subtracts limit on the
// cycle it has reached limit, and registers that event as the ce_os pulse.
module baud_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             clear,
  input  logic [CNT_W-1:0] freq,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit,
  output logic             tick_ev,
  output logic             ce_os
);

  logic [CNT_W-1:0] acc_q, acc_d;
  logic             ce_os_q, ce_os_d;

  // Raw wrap condition (used for config apply) and the tick that is actually
  // issued; idle or a sync request swallows it.
  assign at_limit = (acc_q >= limit);
  assign tick_ev  = enable && !sync && at_limit;

  // Next accumulator value: wrap by limit, otherwise add freq; idle, sync and
  // a config apply all restart counting from zero.
  always_comb begin
    // NOTE: every variable gets a value before any condition so no latch is inferred.
    acc_d = CNT_W'({1'b0, acc_q} + {1'b0, freq});
    if (at_limit) acc_d = acc_q - limit;
    if (!enable || sync || clear) acc_d = '0;
    ce_os_d = tick_ev;
  end

  // Accumulator and tick registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      acc_q   <= '0;
      ce_os_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ce_os_q <= ce_os_d;
    end
  end

  assign ce_os = ce_os_q;

endmodule

// File: rtl/baud_gen_mc.sv
// Multi-config baud generator: fractional oversample ticks, bit-phase
// counter with mid-bit and end-of-bit strobes, and a valid/ready config port
// whose accepted settings take effect at a safe point (idle or tick cycle).
module baud_gen_mc
  import baud_pkg::*;
#(
  parameter int               CNT_W     = 16,
  parameter int               OSR       = 16,
  parameter logic [CNT_W-1:0] DEF_FREQ  = CNT_W'(BAUD_DEF_FREQ),
  parameter logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(BAUD_DEF_LIMIT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_freq,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             sync,
  output logic             ce_os,
  output logic             ce_mid,
  output logic             ce_bit,
  output logic             cfg_err
);

  localparam int              PH_W       = osr_w(OSR);
  localparam logic [PH_W-1:0] PH_MID_PRE = PH_W'(OSR / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OSR - 1);

  baud_cfg_t       act_q, act_d;
  baud_cfg_t       pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            ce_mid_q, ce_mid_d;
  logic            ce_bit_q, ce_bit_d;
  logic            cfg_err_q, cfg_err_d;

  logic            at_limit;
  logic            tick_ev;
  logic            accept;
  logic            cfg_bad;
  logic            apply;

  baud_acc #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .sync     (sync),
    .clear    (apply),
    .freq     (CNT_W'(act_q.freq)),
    .limit    (CNT_W'(act_q.limit)),
    .at_limit (at_limit),
    .tick_ev  (tick_ev),
    .ce_os    (ce_os)
  );

  // Config port: a zero field or a freq+limit sum that would overflow the
  // accumulator is acknowledged but dropped with an error pulse; a good one
  // waits in the pending slot until idle or a wrap cycle makes it safe to use.
  always_comb begin
    accept  = cfg_valid && !pend_valid_q;
    cfg_bad = (cfg_freq == '0) || (cfg_limit == '0) ||
              (((({1'b0, cfg_freq} + {1'b0, cfg_limit}) >> CNT_W)) != '0);
    apply   = pend_valid_q && (!enable || at_limit);

    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (apply) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end else if (accept && !cfg_bad) begin
      pend_d       = '{freq: CFG_W_MAX'(cfg_freq), limit: CFG_W_MAX'(cfg_limit)};
      pend_valid_d = 1'b1;
    end
    cfg_err_d = accept && cfg_bad;
  end

  // Bit phase: advance on each issued tick, strobe when crossing the middle
  // of the bit and when wrapping to the next bit; idle and sync realign to 0.
  always_comb begin
    ph_d = ph_q;
    if (!enable || sync) ph_d = '0;
    else if (tick_ev)    ph_d = ph_q + 1'b1;
    ce_mid_d = tick_ev && (ph_q == PH_MID_PRE);
    ce_bit_d = tick_ev && (ph_q == PH_LAST);
  end

  // Config, phase and strobe registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_q        <= '{freq: CFG_W_MAX'(DEF_FREQ), limit: CFG_W_MAX'(DEF_LIMIT)};
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ph_q         <= '0;
      ce_mid_q     <= 1'b0;
      ce_bit_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ph_q         <= ph_d;
      ce_mid_q     <= ce_mid_d;
      ce_bit_q     <= ce_bit_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_valid_q;
  assign ce_mid    = ce_mid_q;
  assign ce_bit    = ce_bit_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_mc.sv
// Bench for baud_gen_mc: an integer-arithmetic reference model is compared
// against every output on every cycle, and directed scenarios pin exact
// tick positions, counts and handshake timing with literal values.
module tb_baud_gen_mc;

  localparam int CNT_W = 16;
  localparam int OSR   = 16;
  localparam int DEF_F = 1152;
  localparam int DEF_L = 30098;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_freq = '0;
  logic [15:0] cfg_limit = '0;
  logic        cfg_ready, ce_os, ce_mid, ce_bit, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  baud_gen_mc #(.CNT_W(CNT_W), .OSR(OSR)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_freq  (cfg_freq),
    .cfg_limit (cfg_limit),
    .sync      (sync),
    .ce_os     (ce_os),
    .ce_mid    (ce_mid),
    .ce_bit    (ce_bit),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integers: acc value, active/pending config, phase as tick count mod OSR.
  int m_acc, m_freq, m_limit, m_ph, m_pend_f, m_pend_l;
  bit m_pend;
  bit e_os, e_mid, e_bit, e_err;

  bit p_hit, p_fire, p_apply, p_accept, p_bad;
  int p_nph;

  always_comb begin
    p_hit    = (m_acc >= m_limit);
    p_fire   = enable && !sync && p_hit;
    p_apply  = m_pend && (!enable || p_hit);
    p_accept = cfg_valid && !m_pend;
    p_bad    = (cfg_freq == 16'd0) || (cfg_limit == 16'd0) ||
               ((int'(cfg_freq) + int'(cfg_limit)) >= (1 << CNT_W));
    p_nph    = p_fire ? (m_ph + 1) % OSR : m_ph;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_acc <= 0; m_freq <= DEF_F; m_limit <= DEF_L; m_ph <= 0;
      m_pend <= 1'b0; m_pend_f <= 0; m_pend_l <= 0;
      e_os <= 1'b0; e_mid <= 1'b0; e_bit <= 1'b0; e_err <= 1'b0;
    end else begin
      e_os  <= p_fire;
      e_mid <= p_fire && (p_nph == OSR / 2);
      e_bit <= p_fire && (p_nph == 0);
      e_err <= p_accept && p_bad;
      if (!enable || sync || p_apply) m_acc <= 0;
      else if (p_hit)                 m_acc <= m_acc - m_limit;
      else                            m_acc <= m_acc + m_freq;
      m_ph <= (!enable || sync) ? 0 : p_nph;
      if (p_apply) begin
        m_freq <= m_pend_f; m_limit <= m_pend_l; m_pend <= 1'b0;
      end else if (p_accept && !p_bad) begin
        m_pend <= 1'b1; m_pend_f <= int'(cfg_freq); m_pend_l <= int'(cfg_limit);
      end
    end
  end

  // Every-cycle comparison of {cfg_ready, ce_os, ce_mid, ce_bit, cfg_err}.
  always @(negedge clock) begin
    if (!reset)
      check("outputs_vs_model", 64'({cfg_ready, ce_os, ce_mid, ce_bit, cfg_err}),
            64'({!m_pend, e_os, e_mid, e_bit, e_err}));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic wait_os(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ce_os && n < bound);
    check("wait_ce_os", 64'(ce_os), 64'(1));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int first_os, first_mid, bit1, bit2, os_cnt, pre_cnt, mid_at, second_os;
    int last, gap_max, bit_cnt, err_cnt, err_pos, rdy_all;
    logic [11:0] os_bits, rdy_bits;
    int bad_f[4];
    int bad_l[4];
    bad_f = '{0, 5, 32768, 65535};
    bad_l = '{5, 0, 32768, 1};

    // Reset state.
    repeat (2) @(negedge clock);
    check("reset_outputs", 64'({cfg_ready, ce_os, ce_mid, ce_bit, cfg_err}), 64'(5'b10000));
    #2 reset = 1'b0;

    // Load 1/3 while idle: applied on the next idle cycle.
    @(negedge clock);
    check("ready_idle", 64'(cfg_ready), 64'(1));
    cfg_valid = 1'b1; cfg_freq = 16'd1; cfg_limit = 16'd3;
    @(negedge clock);
    cfg_valid = 1'b0;
    check("ready_low_pending", 64'(cfg_ready), 64'(0));
    @(negedge clock);
    check("ready_after_idle_apply", 64'(cfg_ready), 64'(1));

    // 1/3 cadence: ce_os every 4, ce_mid at 32, ce_bit every 64.
    enable = 1'b1;
    first_os = 0; first_mid = 0; bit1 = 0; bit2 = 0; os_cnt = 0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clock);
      if (ce_os) os_cnt++;
      if (ce_os && first_os == 0) first_os = k;
      if (ce_mid && first_mid == 0) first_mid = k;
      if (ce_bit) begin
        if (bit1 == 0) bit1 = k;
        else if (bit2 == 0) bit2 = k;
      end
    end
    check("first_ce_os", 64'(first_os), 64'(4));
    check("first_ce_mid", 64'(first_mid), 64'(32));
    check("first_ce_bit", 64'(bit1), 64'(64));
    check("second_ce_bit", 64'(bit2), 64'(128));
    check("ce_os_count_130", 64'(os_cnt), 64'(32));

    // Sync at phase 9 on a tick cycle: tick swallowed, mid-bit 8 ticks later.
    enable = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b1;
    pre_cnt = 0; os_cnt = 0; mid_at = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (k <= 39 && ce_os) pre_cnt++;
      if (k == 39) sync = 1'b1;
      if (k == 40) begin
        check("sync_suppresses_tick", 64'(ce_os), 64'(0));
        sync = 1'b0;
      end
      if (k > 40) begin
        if (ce_os) os_cnt++;
        if (ce_mid && mid_at == 0) mid_at = os_cnt;
      end
    end
    check("ticks_before_sync", 64'(pre_cnt), 64'(9));
    check("mid_after_sync_ticks", 64'(mid_at), 64'(8));

    // Switch 1/3 -> 1/1 while running.
    enable = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      os_bits[k-1]  = ce_os;
      rdy_bits[k-1] = cfg_ready;
      if (k == 1) begin cfg_valid = 1'b1; cfg_freq = 16'd1; cfg_limit = 16'd1; end
      if (k == 2) cfg_valid = 1'b0;
    end
    check("switch_ce_os_pattern", 64'(os_bits), 64'(12'hAA8));
    check("switch_ready_pattern", 64'(rdy_bits), 64'(12'hFF9));

    // Rejected configs: handshake completes, one error pulse, rate unchanged.
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_freq = 16'(bad_f[i]); cfg_limit = 16'(bad_l[i]);
      err_cnt = 0; err_pos = 0; rdy_all = 1; os_cnt = 0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clock);
        if (k == 1) cfg_valid = 1'b0;
        if (cfg_err) begin
          err_cnt++;
          if (err_pos == 0) err_pos = k;
        end
        if (!cfg_ready) rdy_all = 0;
        if (ce_os) os_cnt++;
      end
      check("bad_cfg_err_count", 64'(err_cnt), 64'(1));
      check("bad_cfg_err_position", 64'(err_pos), 64'(1));
      check("bad_cfg_ready_high", 64'(rdy_all), 64'(1));
      check("bad_cfg_rate_kept", 64'(os_cnt), 64'(3));
    end

    // Sync and config apply on the same cycle: both take effect.
    wait_os(10);
    cfg_valid = 1'b1; cfg_freq = 16'd1; cfg_limit = 16'd3;
    @(negedge clock);
    cfg_valid = 1'b0;
    sync = 1'b1;
    check("ready_low_before_sync_apply", 64'(cfg_ready), 64'(0));
    @(negedge clock);
    sync = 1'b0;
    check("sync_apply_no_tick", 64'(ce_os), 64'(0));
    check("ready_after_sync_apply", 64'(cfg_ready), 64'(1));
    first_os = 0; second_os = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (ce_os) begin
        if (first_os == 0) first_os = k;
        else if (second_os == 0) second_os = k;
      end
    end
    check("after_sync_apply_first", 64'(first_os), 64'(4));
    check("after_sync_apply_second", 64'(second_os), 64'(8));

    // Reset with a config pending, asserted while a tick is showing.
    wait_os(10);
    repeat (3) @(negedge clock);
    cfg_valid = 1'b1; cfg_freq = 16'd1; cfg_limit = 16'd1;
    @(negedge clock);
    cfg_valid = 1'b0;
    check("tick_with_pending", 64'(ce_os), 64'(1));
    check("ready_low_at_tick", 64'(cfg_ready), 64'(0));
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", 64'({cfg_ready, ce_os, ce_mid, ce_bit, cfg_err}), 64'(5'b10000));
    @(negedge clock);
    #2 reset = 1'b0;

    // Defaults over one full period of 31250 cycles.
    first_os = 0; os_cnt = 0; bit_cnt = 0; last = 0; gap_max = 0;
    for (int k = 1; k <= 31250; k++) begin
      @(negedge clock);
      if (ce_os) begin
        os_cnt++;
        if (first_os == 0) first_os = k;
        if (last > 0 && (k - last) > gap_max) gap_max = k - last;
        last = k;
      end
      if (ce_bit) bit_cnt++;
    end
    check("default_first_tick", 64'(first_os), 64'(28));
    check("default_ce_os_count", 64'(os_cnt), 64'(1152));
    check("default_ce_bit_count", 64'(bit_cnt), 64'(72));
    check("default_max_gap", 64'(gap_max), 64'(28));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
